// File: rtl/store_beat_ctrl.sv
// Store-path sequencer: turns one right-aligned LSU store into one or two
// lane-positioned, byte-strobed 64-bit memory beats on a req/ack handshake.
module store_beat_ctrl #(
    parameter int DATA_WIDTH     = 64,
    parameter int ADDR_WIDTH     = 64,
    parameter bit MISALIGN_SPLIT = 1'b1
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_st_valid,
    output logic                  o_st_ready,
    input  logic [ADDR_WIDTH-1:0] i_st_addr,
    input  logic [1:0]            i_st_size,
    input  logic [DATA_WIDTH-1:0] i_st_data,
    output logic                  o_mem_req,
    input  logic                  i_mem_ack,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [DATA_WIDTH-1:0] o_mem_wdata,
    output logic [7:0]            o_mem_strobe,
    output logic                  o_done,
    output logic                  o_misaligned
);

    // state | meaning
    // IDLE  | ready for a store; done/misaligned pulses show here
    // BEAT0 | low (or only) beat requested, waiting for ack
    // BEAT1 | upper beat of a boundary-crossing store, waiting for ack
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BEAT0 = 2'd1;
    localparam logic [1:0] ST_BEAT1 = 2'd2;

    logic [1:0]              state;
    logic [7:0]              hi_strb;
    logic [DATA_WIDTH-1:0]   hi_data;
    logic [2:0]              off;
    logic [2:0]              align_mask;
    logic [7:0]              lane_mask;
    logic [DATA_WIDTH-1:0]   data_mask;
    logic [15:0]             strb16;
    logic [2*DATA_WIDTH-1:0] data128;
    logic                    misaligned;

    always_comb begin
        lane_mask  = 8'h01;
        data_mask  = DATA_WIDTH'(64'hFF);
        align_mask = 3'b000;
        case (i_st_size)
            2'b00: begin lane_mask = 8'h01; data_mask = DATA_WIDTH'(64'hFF);       align_mask = 3'b000; end
            2'b01: begin lane_mask = 8'h03; data_mask = DATA_WIDTH'(64'hFFFF);     align_mask = 3'b001; end
            2'b10: begin lane_mask = 8'h0F; data_mask = DATA_WIDTH'(64'hFFFF_FFFF); align_mask = 3'b011; end
            default: begin lane_mask = 8'hFF; data_mask = '1;                      align_mask = 3'b111; end
        endcase
        off        = i_st_addr[2:0];
        strb16     = {8'h00, lane_mask} << off;
        data128    = {{DATA_WIDTH{1'b0}}, i_st_data & data_mask} << {off, 3'b000};
        misaligned = (off & align_mask) != 3'b000;
    end

    assign o_st_ready = (state == ST_IDLE);
    assign o_mem_req  = (state != ST_IDLE);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= ST_IDLE;
            o_mem_addr   <= '0;
            o_mem_wdata  <= '0;
            o_mem_strobe <= '0;
            hi_strb      <= '0;
            hi_data      <= '0;
            o_done       <= 1'b0;
            o_misaligned <= 1'b0;
        end else begin
            o_done       <= 1'b0;
            o_misaligned <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (i_st_valid) begin
                        if (!MISALIGN_SPLIT && misaligned) begin
                            o_misaligned <= 1'b1;
                        end else begin
                            state        <= ST_BEAT0;
                            o_mem_addr   <= {i_st_addr[ADDR_WIDTH-1:3], 3'b000};
                            o_mem_strobe <= strb16[7:0];
                            o_mem_wdata  <= data128[DATA_WIDTH-1:0];
                            hi_strb      <= strb16[15:8];
                            hi_data      <= data128[2*DATA_WIDTH-1:DATA_WIDTH];
                        end
                    end
                end
                ST_BEAT0: begin
                    if (i_mem_ack) begin
                        if (hi_strb != 8'h00) begin
                            // request stays up; the upper beat replaces the lower on this edge
                            state        <= ST_BEAT1;
                            o_mem_addr   <= o_mem_addr + ADDR_WIDTH'(8);
                            o_mem_strobe <= hi_strb;
                            o_mem_wdata  <= hi_data;
                        end else begin
                            state        <= ST_IDLE;
                            o_done       <= 1'b1;
                            o_mem_addr   <= '0;
                            o_mem_strobe <= '0;
                            o_mem_wdata  <= '0;
                        end
                    end
                end
                ST_BEAT1: begin
                    if (i_mem_ack) begin
                        state        <= ST_IDLE;
                        o_done       <= 1'b1;
                        o_mem_addr   <= '0;
                        o_mem_strobe <= '0;
                        o_mem_wdata  <= '0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_store_beat_ctrl.sv
// Directed bench for store_beat_ctrl: three instances (64-bit split, 32-bit
// split, 64-bit reject-misaligned) checked against a byte-lane beat model.
module tb_store_beat_ctrl;

    typedef struct {
        logic [63:0] addr;
        logic [7:0]  strb;
        logic [63:0] wdata;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid;
    logic [63:0] addr;
    logic [1:0]  size;
    logic [63:0] data;
    logic        ack;
    int          sel;

    logic        rdy_a, req_a, done_a, mis_a;
    logic [63:0] addr_a, wdata_a;
    logic [7:0]  strb_a;
    logic        rdy_b, req_b, done_b, mis_b;
    logic [31:0] addr_b;
    logic [63:0] wdata_b;
    logic [7:0]  strb_b;
    logic        rdy_c, req_c, done_c, mis_c;
    logic [63:0] addr_c, wdata_c;
    logic [7:0]  strb_c;

    logic        o_rdy, o_req, o_done, o_mis;
    logic [63:0] o_addr, o_wdata;
    logic [7:0]  o_strb;

    beat_t q[$];
    int    n_assert = 0;
    int    n_fail   = 0;

    always #5 clk = ~clk;

    store_beat_ctrl #(.DATA_WIDTH(64), .ADDR_WIDTH(64), .MISALIGN_SPLIT(1'b1)) u_dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_st_valid(valid && sel == 0), .o_st_ready(rdy_a),
        .i_st_addr(addr), .i_st_size(size), .i_st_data(data),
        .o_mem_req(req_a), .i_mem_ack(ack), .o_mem_addr(addr_a), .o_mem_wdata(wdata_a),
        .o_mem_strobe(strb_a), .o_done(done_a), .o_misaligned(mis_a));

    store_beat_ctrl #(.DATA_WIDTH(64), .ADDR_WIDTH(32), .MISALIGN_SPLIT(1'b1)) u_dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_st_valid(valid && sel == 1), .o_st_ready(rdy_b),
        .i_st_addr(addr[31:0]), .i_st_size(size), .i_st_data(data),
        .o_mem_req(req_b), .i_mem_ack(ack), .o_mem_addr(addr_b), .o_mem_wdata(wdata_b),
        .o_mem_strobe(strb_b), .o_done(done_b), .o_misaligned(mis_b));

    store_beat_ctrl #(.DATA_WIDTH(64), .ADDR_WIDTH(64), .MISALIGN_SPLIT(1'b0)) u_dut_c (
        .i_clk(clk), .i_rst_n(rst_n), .i_st_valid(valid && sel == 2), .o_st_ready(rdy_c),
        .i_st_addr(addr), .i_st_size(size), .i_st_data(data),
        .o_mem_req(req_c), .i_mem_ack(ack), .o_mem_addr(addr_c), .o_mem_wdata(wdata_c),
        .o_mem_strobe(strb_c), .o_done(done_c), .o_misaligned(mis_c));

    always_comb begin
        o_rdy = rdy_a; o_req = req_a; o_done = done_a; o_mis = mis_a;
        o_addr = addr_a; o_wdata = wdata_a; o_strb = strb_a;
        if (sel == 1) begin
            o_rdy = rdy_b; o_req = req_b; o_done = done_b; o_mis = mis_b;
            o_addr = {32'h0, addr_b}; o_wdata = wdata_b; o_strb = strb_b;
        end else if (sel == 2) begin
            o_rdy = rdy_c; o_req = req_c; o_done = done_c; o_mis = mis_c;
            o_addr = addr_c; o_wdata = wdata_c; o_strb = strb_c;
        end
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one store on instance s, push the modelled beats, then ack each
    // beat after 'hold' wait cycles and check beats, latency and done.
    task automatic run_store(input int s, input logic [63:0] a, input logic [1:0] sz,
                             input logic [63:0] d, input int hold);
        int          n, off, p, cyc, w, nbeats;
        logic [63:0] amask;
        logic        mis;
        beat_t       b0, b1;
        n     = 1 << sz;
        off   = int'(a[2:0]);
        mis   = (s == 2) && ((off & (n - 1)) != 0);
        amask = (s == 1) ? 64'hFFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
        b0 = '{addr: (a & ~64'h7) & amask, strb: 8'h00, wdata: 64'h0};
        b1 = '{addr: ((a & ~64'h7) + 64'h8) & amask, strb: 8'h00, wdata: 64'h0};
        for (int i = 0; i < n; i++) begin
            p = off + i;
            if (p < 8) begin
                b0.strb[p] = 1'b1;
                b0.wdata[8*p +: 8] = d[8*i +: 8];
            end else begin
                b1.strb[p-8] = 1'b1;
                b1.wdata[8*(p-8) +: 8] = d[8*i +: 8];
            end
        end
        nbeats = 0;
        if (!mis) begin
            q.push_back(b0);
            nbeats = 1;
            if (b1.strb != 8'h00) begin
                q.push_back(b1);
                nbeats = 2;
            end
        end
        sel = s;
        @(negedge clk);
        check("ready_idle", 128'(o_rdy), 128'(1));
        valid = 1'b1; addr = a; size = sz; data = d;
        @(negedge clk);
        valid = 1'b0; addr = {$urandom, $urandom}; data = {$urandom, $urandom}; size = 2'(~sz);
        if (mis) begin
            check("mis_pulse", 128'(o_mis), 128'(1));
            check("mis_no_req", 128'(o_req), 128'(0));
            check("mis_no_done", 128'(o_done), 128'(0));
            @(negedge clk);
            check("mis_one_cycle", 128'(o_mis), 128'(0));
            check("mis_still_no_req", 128'(o_req), 128'(0));
            return;
        end
        check("no_mis", 128'(o_mis), 128'(0));
        cyc = 1;
        w = 0;
        while (q.size() > 0 && cyc < 64) begin
            check("req_held", 128'(o_req), 128'(1));
            check("ready_busy", 128'(o_rdy), 128'(0));
            check("done_early", 128'(o_done), 128'(0));
            check("beat_addr", 128'(o_addr), 128'(q[0].addr));
            check("beat_strb", 128'(o_strb), 128'(q[0].strb));
            check("beat_wdata", 128'(o_wdata), 128'(q[0].wdata));
            if (w == hold) begin
                ack = 1'b1;
                void'(q.pop_front());
                w = 0;
            end else begin
                ack = 1'b0;
                w++;
            end
            @(negedge clk);
            cyc++;
        end
        ack = 1'b0;
        q.delete();
        check("done_pulse", 128'(o_done), 128'(1));
        check("done_cycle", 128'(cyc), 128'(nbeats * (hold + 1) + 1));
        check("ready_on_done", 128'(o_rdy), 128'(1));
        check("req_dropped", 128'(o_req), 128'(0));
        @(negedge clk);
        check("done_single", 128'(o_done), 128'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; valid = 1'b0; addr = '0; size = '0; data = '0; ack = 1'b0; sel = 0;
        #1;
        check("rst_req", 128'(o_req), 128'(0));
        check("rst_done", 128'(o_done), 128'(0));
        check("rst_mis", 128'(o_mis), 128'(0));
        check("rst_addr", 128'(o_addr), 128'(0));
        check("rst_wdata", 128'(o_wdata), 128'(0));
        check("rst_strb", 128'(o_strb), 128'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_ready", 128'(o_rdy), 128'(1));

        run_store(0, 64'h1000, 2'b11, 64'h1122_3344_5566_7788, 0);
        run_store(0, 64'h1003, 2'b00, 64'hFFFF_FFAB, 0);
        run_store(0, 64'h1006, 2'b10, 64'hDEAD_BEEF, 0);
        run_store(0, 64'h1006, 2'b10, 64'hDEAD_BEEF, 3);
        run_store(0, 64'h1007, 2'b01, 64'hA5C3, 1);
        run_store(0, 64'h2005, 2'b11, 64'h0102_0304_0506_0708, 2);
        run_store(1, 64'hFFFF_FFFC, 2'b11, 64'h0123_4567_89AB_CDEF, 0);
        run_store(2, 64'h1001, 2'b01, 64'h1234, 0);
        run_store(2, 64'h1004, 2'b10, 64'hCAFE_F00D, 1);

        // ack with no request outstanding must not complete anything
        sel = 0;
        ack = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("idle_ack_no_req", 128'(o_req), 128'(0));
            check("idle_ack_no_done", 128'(o_done), 128'(0));
        end
        ack = 1'b0;
        run_store(0, 64'h3000, 2'b10, 64'h5555_AAAA, 1);

        // reset while the upper beat waits for ack
        valid = 1'b1; addr = 64'h1006; size = 2'b10; data = 64'hDEAD_BEEF;
        @(negedge clk);
        valid = 1'b0; ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        check("pre_rst_beat1_req", 128'(o_req), 128'(1));
        check("pre_rst_beat1_addr", 128'(o_addr), 128'(64'h1008));
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_req", 128'(o_req), 128'(0));
        check("rst_async_strb", 128'(o_strb), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("rst_no_done", 128'(o_done), 128'(0));
            check("rst_no_req", 128'(o_req), 128'(0));
        end
        run_store(0, 64'h1000, 2'b11, 64'h8877_6655_4433_2211, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
